stream_demux_1x4: RTL and testbench

- Sequential, flow-controlled front end to the 1x4 demultiplex path: routes a valid/ready input stream to one of four output channels, each buffered by its own FIFO.
- Destination is either the per-beat select `in_sel` or an internal round-robin pointer.
- Sits between the upstream producer and the four downstream consumers. It replaces the purely combinational steering with backpressure-aware buffering.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/stream_demux_1x4_chan_fifo.sv | 68 ++++++
 rtl/stream_demux_1x4.sv | 78 +++++++
 tb/tb_stream_demux_1x4.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1x4 stream demultiplexer.
// Contents:
//   NUM_CH, SEL_W - channel count and the width of a channel index
//   mode_e        - routing mode (MODE_SEL: by in_sel, MODE_RR: round-robin)
//   cnt_w()       - occupancy counter width for a FIFO of a given depth
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // The counter must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_demux_1x4_chan_fifo.sv
// chan_fifo: single-clock synchronous FIFO used as one output channel buffer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (ignored while full)
//   push_data   - entry to write
//   pop         - drop the head entry (ignored while empty)
//   head_data   - current head entry; 0 while empty
//   count       - number of stored entries, 0..DEPTH
//   full, empty - decoded from count
module chan_fifo
  import demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Stale storage is masked so the head reads as 0 whenever nothing is held.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage carries payload only, so it is never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally; full/empty come from count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_1x4.sv
// stream_demux_1x4: routes a valid/ready stream into one of four buffered
// output channels, chosen per beat by in_sel or by a round-robin pointer.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   mode_rr             - 0: route by in_sel, 1: route by rr_ptr
//   in_valid/in_ready   - upstream handshake
//   in_data, in_sel     - upstream payload and requested channel
//   out_valid/out_ready - per-channel downstream handshake (bit k = channel k)
//   out_data            - channel k head at [k*DATA_W +: DATA_W]
//   occ                 - channel k occupancy at [k*CNT_W +: CNT_W]
//   rr_ptr              - round-robin pointer, exposed for observability
module stream_demux_1x4
  import demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_rr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]  occ,
  output logic [SEL_W-1:0]         rr_ptr
);

  logic [SEL_W-1:0]  dst;
  logic [NUM_CH-1:0] full_v;
  logic [NUM_CH-1:0] empty_v;
  logic [NUM_CH-1:0] push_v;
  logic [NUM_CH-1:0] pop_v;
  logic              accept;

  assign dst = (mode_e'(mode_rr) == MODE_RR) ? rr_ptr : in_sel;

  // Only registered occupancy feeds in_ready: a pop in the same cycle does
  // not open a slot, which keeps out_ready off the in_ready path.
  assign in_ready = ~full_v[dst];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push_v[k]    = accept & (dst == SEL_W'(k));
    assign pop_v[k]     = out_valid[k] & out_ready[k];
    assign out_valid[k] = ~empty_v[k];

    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_v[k]),
      .push_data (in_data),
      .pop       (pop_v[k]),
      .head_data (out_data[k*DATA_W +: DATA_W]),
      .count     (occ[k*CNT_W +: CNT_W]),
      .full      (full_v[k]),
      .empty     (empty_v[k])
    );
  end

  // The pointer never skips a full channel; it advances only on a beat
  // actually taken in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && (mode_e'(mode_rr) == MODE_RR)) begin
      rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_1x4.sv
module tb_stream_demux_1x4;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                mode_rr;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
  logic [4*CNT_W-1:0]  occ;
  logic [1:0]          rr_ptr;

  stream_demux_1x4 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per channel plus the round-robin index.
  logic [7:0] mq [4][$];
  int         mrr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    mrr = 0;
  endtask

  task automatic model_check();
    int d;
    d = mode_rr ? mrr : int'(in_sel);
    check("in_ready", 32'(in_ready), 32'(mq[d].size() < DEPTH));
    check("rr_ptr", 32'(rr_ptr), 32'(mrr));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("occ%0d", k), 32'(occ[k*CNT_W +: CNT_W]), 32'(mq[k].size()));
      check($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
      if (mq[k].size() != 0)
        check($sformatf("head%0d", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(mq[k][0]));
    end
  endtask

  // Check against the model, take one clock edge, then advance the model.
  task automatic step();
    int  d;
    bit  acc;
    logic [3:0] ordy;
    logic [7:0] dat;
    bit  m;
    model_check();
    m    = mode_rr;
    d    = m ? mrr : int'(in_sel);
    acc  = in_valid && (mq[d].size() < DEPTH);
    ordy = out_ready;
    dat  = in_data;
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
    if (acc) begin
      mq[d].push_back(dat);
      if (m) mrr = (mrr + 1) % 4;
    end
    #1;
  endtask

  task automatic drive(input logic m, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [3:0] r);
    mode_rr   = m;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  typedef struct {
    logic       m;
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [1:0] e_rr;
    logic [7:0] e_occ;
    int         ch;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Single beat to channel 2, then a drain.
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000, 2'd0, 8'h00, -1, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0000, 1'b1, 4'b0100, 2'd0, 8'h10,  2, 8'hA5};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b0100, 2'd0, 8'h10,  2, 8'hA5};
    // Channel 1 fills; third beat held until the slot freed by a pop is visible.
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h01, 4'b0000, 1'b1, 4'b0000, 2'd0, 8'h00, -1, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h02, 4'b0000, 1'b1, 4'b0010, 2'd0, 8'h04,  1, 8'h01};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 8'h03, 4'b0000, 1'b0, 4'b0010, 2'd0, 8'h08,  1, 8'h01};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 8'h03, 4'b0010, 1'b0, 4'b0010, 2'd0, 8'h08,  1, 8'h01};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 8'h03, 4'b0000, 1'b1, 4'b0010, 2'd0, 8'h04,  1, 8'h02};
    tbl[8]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, 4'b0010, 2'd0, 8'h08,  1, 8'h02};
    tbl[9]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0010, 2'd0, 8'h04,  1, 8'h03};
    // Round-robin burst 10..15 with all consumers ready.
    tbl[10] = '{1'b1, 1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00, -1, 8'h00};
    tbl[11] = '{1'b1, 1'b1, 2'd0, 8'h11, 4'b1111, 1'b1, 4'b0001, 2'd1, 8'h01,  0, 8'h10};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 8'h12, 4'b1111, 1'b1, 4'b0010, 2'd2, 8'h04,  1, 8'h11};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 8'h13, 4'b1111, 1'b1, 4'b0100, 2'd3, 8'h10,  2, 8'h12};
    tbl[14] = '{1'b1, 1'b1, 2'd0, 8'h14, 4'b1111, 1'b1, 4'b1000, 2'd0, 8'h40,  3, 8'h13};
    tbl[15] = '{1'b1, 1'b1, 2'd0, 8'h15, 4'b1111, 1'b1, 4'b0001, 2'd1, 8'h01,  0, 8'h14};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0010, 2'd2, 8'h04,  1, 8'h15};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 2'd2, 8'h00, -1, 8'h00};

    model_reset();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst occ", 32'(occ), 32'h0);
    check("rst rr_ptr", 32'(rr_ptr), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    check("rst out_data", out_data, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].m, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("vec%0d rr_ptr", i), 32'(rr_ptr), 32'(tbl[i].e_rr));
      check($sformatf("vec%0d occ", i), 32'(occ), 32'(tbl[i].e_occ));
      if (tbl[i].ch >= 0)
        check($sformatf("vec%0d data", i), 32'(out_data[tbl[i].ch*DATA_W +: DATA_W]),
              32'(tbl[i].e_dat));
      step();
    end

    // Return to a known pointer via asynchronous reset.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill channel 0 in select mode, then try round-robin with rr_ptr=0.
    drive(1'b0, 1'b1, 2'd0, 8'h50, 4'b0000); #1; step();
    drive(1'b0, 1'b1, 2'd0, 8'h51, 4'b0000); #1; step();
    drive(1'b1, 1'b1, 2'd0, 8'h60, 4'b0000); #1;
    check("rr blocked in_ready", 32'(in_ready), 32'h0);
    step();
    check("rr blocked rr_ptr", 32'(rr_ptr), 32'h0);
    check("rr blocked in_ready2", 32'(in_ready), 32'h0);
    check("rr blocked occ", 32'(occ), 32'h02);

    // Channel 3: one entry, then a simultaneous push and pop.
    drive(1'b0, 1'b1, 2'd3, 8'hAA, 4'b0000); #1; step();
    drive(1'b0, 1'b1, 2'd3, 8'hBB, 4'b1000); #1;
    check("ch3 pre head", 32'(out_data[3*DATA_W +: DATA_W]), 32'hAA);
    step();
    check("ch3 occ", 32'(occ[3*CNT_W +: CNT_W]), 32'h1);
    check("ch3 head", 32'(out_data[3*DATA_W +: DATA_W]), 32'hBB);

    // Make every channel non-empty with rr_ptr away from 0.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001); #1; step();
    drive(1'b1, 1'b1, 2'd0, 8'hC0, 4'b0000); #1; step();
    drive(1'b1, 1'b1, 2'd0, 8'hC1, 4'b0000); #1; step();
    drive(1'b1, 1'b1, 2'd0, 8'hC2, 4'b0000); #1; step();
    check("pre-rst out_valid", 32'(out_valid), 32'hF);
    check("pre-rst rr_ptr", 32'(rr_ptr), 32'h3);

    // Asynchronous reset between clock edges.
    drive(1'b1, 1'b1, 2'd0, 8'hC3, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'h0);
    check("async occ", 32'(occ), 32'h0);
    check("async rr_ptr", 32'(rr_ptr), 32'h0);
    model_reset();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'h1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
      #1;
      step();
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    #1;
    model_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
